// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_meter_pkg
// Brief    : Shared state encoding and default sizes for the pulse burst meter.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

    localparam int C_CNT_W  = 8;
    localparam int C_PCNT_W = 4;
    localparam int C_GAP    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        REPORT = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Two-flop synchroniser plus delay flop with rise/fall detection.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge
    import pulse_meter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign s    = sync_q;
    assign rise =  sync_q & ~dly_q;
    assign fall = ~sync_q &  dly_q;

endmodule
`default_nettype wire

// File: rtl/pulse_burst_meter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_meter
// Brief    : Measures pulse count and min/max high width per burst and reports
//            one summary per burst over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W  = C_CNT_W,
    parameter int PCNT_W = C_PCNT_W,
    parameter int GAP    = C_GAP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              signal,
    input  logic              ready,
    output logic              valid,
    output logic [PCNT_W-1:0] pulses,
    output logic [CNT_W-1:0]  high_min,
    output logic [CNT_W-1:0]  high_max,
    output logic              overflow,
    output logic              busy
);

    localparam logic [PCNT_W-1:0] C_PMAX = {PCNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  C_HMAX = {CNT_W{1'b1}};
    localparam logic [7:0]        C_LEND = 8'(GAP - 1);

    logic s, rise, fall;

    sync_edge u_sync (
        .clock (clock),
        .reset (reset),
        .d     (signal),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e              state_q,    state_d;
    logic [PCNT_W-1:0]   pcnt_q,     pcnt_d;
    logic [CNT_W-1:0]    hcnt_q,     hcnt_d;
    logic [7:0]          lcnt_q,     lcnt_d;
    logic [CNT_W-1:0]    acc_min_q,  acc_min_d;
    logic [CNT_W-1:0]    acc_max_q,  acc_max_d;
    logic                acc_ovf_q,  acc_ovf_d;
    logic                valid_q,    valid_d;
    logic [PCNT_W-1:0]   pulses_q,   pulses_d;
    logic [CNT_W-1:0]    high_min_q, high_min_d;
    logic [CNT_W-1:0]    high_max_q, high_max_d;
    logic                overflow_q, overflow_d;
    logic                busy_q,     busy_d;

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        hcnt_d     = hcnt_q;
        lcnt_d     = lcnt_q;
        acc_min_d  = acc_min_q;
        acc_max_d  = acc_max_q;
        acc_ovf_d  = acc_ovf_q;
        valid_d    = valid_q;
        pulses_d   = pulses_q;
        high_min_d = high_min_q;
        high_max_d = high_max_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (enable && rise) begin
                    state_d   = HIGH;
                    pcnt_d    = PCNT_W'(1);
                    hcnt_d    = CNT_W'(1);
                    acc_min_d = C_HMAX;
                    acc_max_d = '0;
                    acc_ovf_d = 1'b0;
                end
            end
            HIGH: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fall) begin
                    if (hcnt_q < acc_min_q) acc_min_d = hcnt_q;
                    if (hcnt_q > acc_max_q) acc_max_d = hcnt_q;
                    lcnt_d  = 8'd1;
                    state_d = LOW;
                end else if (s) begin
                    if (hcnt_q == C_HMAX) acc_ovf_d = 1'b1;
                    else                  hcnt_d    = hcnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                // A rise always wins, so a low run of GAP-1 cycles keeps the burst
                if (!enable) begin
                    state_d = IDLE;
                end else if (rise) begin
                    if (pcnt_q == C_PMAX) acc_ovf_d = 1'b1;
                    else                  pcnt_d    = pcnt_q + PCNT_W'(1);
                    hcnt_d  = CNT_W'(1);
                    state_d = HIGH;
                end else if (!s && lcnt_q == C_LEND) begin
                    state_d    = REPORT;
                    valid_d    = 1'b1;
                    pulses_d   = pcnt_q;
                    high_min_d = acc_min_q;
                    high_max_d = acc_max_q;
                    overflow_d = acc_ovf_q;
                end else begin
                    lcnt_d = lcnt_q + 8'd1;
                end
            end
            REPORT: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            acc_min_q  <= '1;
            acc_max_q  <= '0;
            acc_ovf_q  <= 1'b0;
            valid_q    <= 1'b0;
            pulses_q   <= '0;
            high_min_q <= '0;
            high_max_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            acc_min_q  <= acc_min_d;
            acc_max_q  <= acc_max_d;
            acc_ovf_q  <= acc_ovf_d;
            valid_q    <= valid_d;
            pulses_q   <= pulses_d;
            high_min_q <= high_min_d;
            high_max_q <= high_max_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign valid    = valid_q;
    assign pulses   = pulses_q;
    assign high_min = high_min_q;
    assign high_max = high_max_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_burst_meter
// Brief    : Self-checking bench: table of bursts plus hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_meter;

    localparam int GAP = 16;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic       signal = 1'b0;
    logic       ready  = 1'b1;
    logic       valid;
    logic [3:0] pulses;
    logic [7:0] high_min;
    logic [7:0] high_max;
    logic       overflow;
    logic       busy;

    pulse_burst_meter #(.CNT_W(8), .PCNT_W(4), .GAP(GAP)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .signal   (signal),
        .ready    (ready),
        .valid    (valid),
        .pulses   (pulses),
        .high_min (high_min),
        .high_max (high_max),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int n;
        int hi0, hi1, hi2, hi3;
        int lo;
        int ep, emin, emax, eovf;
    } vec_t;

    typedef struct {
        int p, mn, mx, ov;
    } exp_t;

    exp_t sb[$];
    vec_t vec[5];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_reports = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic vec_t mk(input int n, h0, h1, h2, h3, lo, ep, emn, emx, eov);
        vec_t v;
        v.n = n; v.hi0 = h0; v.hi1 = h1; v.hi2 = h2; v.hi3 = h3; v.lo = lo;
        v.ep = ep; v.emin = emn; v.emax = emx; v.eovf = eov;
        return v;
    endfunction

    function automatic int hi_of(input vec_t v, input int i);
        case (i)
            0:       return v.hi0;
            1:       return v.hi1;
            2:       return v.hi2;
            default: return v.hi3;
        endcase
    endfunction

    // Scoreboard side: every accepted report is compared with the oldest expectation
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset && valid && ready) begin
            n_reports++;
            if (sb.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pulses",   int'(pulses),   e.p);
                check("high_min", int'(high_min), e.mn);
                check("high_max", int'(high_max), e.mx);
                check("overflow", int'(overflow), e.ov);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        signal = 1'b1;
        repeat (hi) tick();
        signal = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_report(input string name, input int target, input int budget);
        int k = 0;
        while (n_reports < target && k < budget) begin
            tick();
            k++;
        end
        check(name, int'(n_reports >= target), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int base;
        int k;
        bit stable;

        vec[0] = mk(3, 4, 4, 4, 0,  4,  3, 4, 4, 0);
        vec[1] = mk(3, 2, 5, 3, 0,  4,  3, 2, 5, 0);
        vec[2] = mk(2, 3, 3, 0, 0, 15,  2, 3, 3, 0);
        vec[3] = mk(1, 1, 0, 0, 0,  4,  1, 1, 1, 0);
        vec[4] = mk(4, 7, 1, 9, 2,  2,  4, 1, 9, 0);

        // Reset held with the input toggling
        repeat (3) begin
            @(posedge clock);
            #2 signal = 1'b1;
            #4 signal = 1'b0;
        end
        @(negedge clock);
        check("rst_valid",    int'(valid),    0);
        check("rst_pulses",   int'(pulses),   0);
        check("rst_high_min", int'(high_min), 0);
        check("rst_high_max", int'(high_max), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy",     int'(busy),     0);

        // Release with input already high: a held level is not a fresh rise
        signal = 1'b1;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (6) tick();
        enable = 1'b1;
        repeat (6) tick();
        check("held_high_busy",  int'(busy),  0);
        check("held_high_valid", int'(valid), 0);
        signal = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 5; i++) begin
            base = n_reports;
            sb.push_back('{vec[i].ep, vec[i].emin, vec[i].emax, vec[i].eovf});
            for (int j = 0; j < vec[i].n; j++)
                pulse(hi_of(vec[i], j), (j == vec[i].n - 1) ? 0 : vec[i].lo);
            wait_report("vec_report", base + 1, GAP + 40);
            repeat (4) tick();
        end

        // Report latency relative to the last fall, and exactly one report
        base = n_reports;
        sb.push_back('{3, 4, 4, 0});
        pulse(4, 4);
        pulse(4, 4);
        pulse(4, 0);
        k = 0;
        while (!valid && k < 40) begin
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        check("valid_latency", k, GAP + 2);
        repeat (GAP + 10) tick();
        check("nominal_one_report", n_reports - base, 1);

        // Low run of exactly GAP ends the burst; the rise landing in REPORT is dropped
        base = n_reports;
        sb.push_back('{1, 3, 3, 0});
        sb.push_back('{1, 6, 6, 0});
        pulse(3, 16);
        pulse(3, 4);
        pulse(6, 0);
        wait_report("gap16_reports", base + 2, 3 * GAP + 40);
        repeat (GAP + 10) tick();
        check("gap16_count", n_reports - base, 2);

        // Pulse counter saturation
        base = n_reports;
        sb.push_back('{15, 2, 2, 1});
        for (int j = 0; j < 17; j++) pulse(2, (j == 16) ? 0 : 2);
        wait_report("sat_pulses", base + 1, GAP + 40);
        repeat (4) tick();

        // Width saturation
        base = n_reports;
        sb.push_back('{1, 255, 255, 1});
        pulse(300, 0);
        wait_report("sat_width", base + 1, GAP + 40);
        repeat (4) tick();

        // Backpressure: report held while pulses arrive and are ignored
        base = n_reports;
        ready = 1'b0;
        sb.push_back('{1, 3, 3, 0});
        pulse(3, 0);
        k = 0;
        while (!valid && k < GAP + 40) begin
            tick();
            k++;
        end
        check("bp_valid", int'(valid), 1);
        stable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j == 1 || j == 5) signal = 1'b1;
            if (j == 3 || j == 7) signal = 1'b0;
            tick();
            if (!(valid && pulses == 4'd1 && high_min == 8'd3 &&
                  high_max == 8'd3 && !overflow)) stable = 1'b0;
        end
        check("bp_hold", int'(stable), 1);
        check("bp_no_report_yet", n_reports - base, 0);
        ready = 1'b1;
        tick();
        check("bp_valid_drop", int'(valid), 0);
        check("bp_idle_busy",  int'(busy),  0);
        repeat (GAP + 10) tick();
        check("bp_one_report", n_reports - base, 1);

        // Enable drop during HIGH discards the burst
        base = n_reports;
        signal = 1'b1;
        repeat (5) tick();
        check("abort_busy_high", int'(busy), 1);
        enable = 1'b0;
        repeat (2) tick();
        check("abort_busy_low", int'(busy), 0);
        signal = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (GAP + 10) tick();
        check("abort_no_report", n_reports - base, 0);

        // Asynchronous reset while in LOW
        base = n_reports;
        pulse(3, 0);
        repeat (6) tick();
        check("mid_low_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid",    int'(valid),    0);
        check("arst_pulses",   int'(pulses),   0);
        check("arst_high_min", int'(high_min), 0);
        check("arst_high_max", int'(high_max), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_busy",     int'(busy),     0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (GAP + 10) tick();
        check("arst_no_report", n_reports - base, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
